// File: rtl/linked_list_walker.sv
// rtl/linked_list_walker.sv - walks a linked list held in a ROM and streams each payload out
// Each entry is {next, payload}. A node limit stops the walk if the list loops back on itself.
module linked_list_walker #(
    parameter int                DATA_W    = 8,
    parameter int                PTR_W     = 4,
    parameter int                PAY_W     = DATA_W - PTR_W,
    parameter logic [PTR_W-1:0]  NULL_PTR  = {PTR_W{1'b1}},
    parameter int                MAX_NODES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PTR_W-1:0]  head,
    output logic [PTR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0] rom_cont,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PAY_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [4:0]        node_count
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_NODES);

    typedef enum logic {IDLE, WALK} state_t;

    state_t           state;
    logic [PTR_W-1:0] cur;
    logic [PTR_W-1:0] next_ptr;
    logic [4:0]       cnt_inc;
    logic             walking;

    assign walking    = (state == WALK);
    assign next_ptr   = rom_cont[DATA_W-1:PAY_W];
    assign cnt_inc    = node_count + 5'd1;
    assign rom_addr   = cur;
    assign busy       = walking;
    assign out_valid  = walking;
    assign out_data   = rom_cont[PAY_W-1:0];
    assign out_last   = walking && (next_ptr == NULL_PTR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            node_count <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        node_count <= '0;
                        if (head != NULL_PTR) begin
                            cur   <= head;
                            state <= WALK;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WALK: begin
                    // Everything holds under backpressure; the ROM keeps presenting the same node.
                    if (out_ready) begin
                        node_count <= cnt_inc;
                        if (next_ptr == NULL_PTR) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else if (cnt_inc == MAX_CNT) begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end else begin
                            cur <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_linked_list_walker.sv
// tb/tb_linked_list_walker.sv - directed self-checking bench for linked_list_walker
module tb_linked_list_walker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] head = 4'h0;
    logic [3:0] rom_addr;
    logic [7:0] rom_cont;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] node_count;

    logic [7:0] rom [16];

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] dq[$];
    logic       lq[$];
    bit         saw_done, saw_err, finished;
    int         done_cyc, err_cyc, last_cyc, valid_cycles, first_valid;

    always #5 clk = ~clk;

    assign rom_cont = rom[rom_addr];

    linked_list_walker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .head       (head),
        .rom_addr   (rom_addr),
        .rom_cont   (rom_cont),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .node_count (node_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'hFF;
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready toggles, stalling first
    task automatic walk(input logic [3:0] h, input int mode);
        logic [3:0] held;
        bit         hold_pending;
        int         cyc;
        dq.delete();
        lq.delete();
        saw_done = 0; saw_err = 0; finished = 0;
        done_cyc = -1; err_cyc = -1; last_cyc = -1;
        valid_cycles = 0; first_valid = 0;
        hold_pending = 0; held = '0;
        @(negedge clk);
        start = 1'b1;
        head  = h;
        @(negedge clk);
        start = 1'b0;
        first_valid = out_valid;
        cyc = 0;
        while (!finished && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
            if (hold_pending) check("hold_data", {28'd0, out_data}, {28'd0, held});
            hold_pending = 0;
            if (done) begin saw_done = 1; done_cyc = cyc; finished = 1; end
            if (err)  begin saw_err = 1; err_cyc = cyc; finished = 1; end
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                dq.push_back(out_data);
                lq.push_back(out_last);
                last_cyc = cyc;
            end else if (out_valid) begin
                held = out_data;
                hold_pending = 1;
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) check("walk_timeout", 32'd0, 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic check_list1(input string tag);
        check({tag, "_beats"}, dq.size(), 3);
        if (dq.size() == 3) begin
            check({tag, "_d0"}, {28'd0, dq[0]}, 32'd1);
            check({tag, "_d1"}, {28'd0, dq[1]}, 32'd2);
            check({tag, "_d2"}, {28'd0, dq[2]}, 32'd7);
            check({tag, "_last"}, {29'd0, lq[0], lq[1], lq[2]}, 32'b001);
        end
        check({tag, "_done"}, saw_done, 1);
        check({tag, "_err"}, saw_err, 0);
        check({tag, "_done_lat"}, done_cyc, last_cyc + 1);
        check({tag, "_count"}, node_count, 3);
    endtask

    initial begin
        clear_rom();
        rom[0] = 8'h31; rom[3] = 8'h52; rom[5] = 8'hF7;
        repeat (2) @(negedge clk);
        check("rst_addr",  rom_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_err",   err, 0);
        check("rst_count", node_count, 0);
        rst = 1'b0;

        // 1: three-node list at full throughput
        walk(4'h0, 0);
        check("t1_first_valid", first_valid, 1);
        check_list1("t1");
        check("t1_idle_valid", out_valid, 0);

        // 2: same list under toggling backpressure
        walk(4'h0, 1);
        check_list1("t2");

        // 3: empty list
        walk(4'hF, 0);
        check("t3_done", saw_done, 1);
        check("t3_done_cyc", done_cyc, 0);
        check("t3_valid", valid_cycles, 0);
        check("t3_count", node_count, 0);

        // 4: cyclic list 0 -> 1 -> 0 ...
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h01;
        walk(4'h0, 0);
        check("t4_beats", dq.size(), 15);
        for (int i = 0; i < dq.size(); i++) check("t4_data", {28'd0, dq[i]}, i % 2);
        check("t4_err", saw_err, 1);
        check("t4_done", saw_done, 0);
        check("t4_err_lat", err_cyc, last_cyc + 1);
        check("t4_count", node_count, 15);
        @(negedge clk);
        check("t4_idle", busy, 0);

        // 5: start during walk ignored, then mid-walk reset
        clear_rom();
        rom[0] = 8'h31; rom[3] = 8'h52; rom[5] = 8'hF7; rom[7] = 8'hF9;
        @(negedge clk);
        start = 1'b1; head = 4'h0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("t5_valid", out_valid, 1);
        check("t5_d0", out_data, 1);
        start = 1'b1; head = 4'h7;
        @(negedge clk);
        start = 1'b0;
        check("t5_addr_hold", rom_addr, 0);
        check("t5_data_hold", out_data, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_addr_next", rom_addr, 3);
        check("t5_d1", out_data, 2);
        check("t5_count", node_count, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_count", node_count, 0);
        @(negedge clk);
        rst = 1'b0;
        walk(4'h0, 0);
        check_list1("t5_fresh");

        // 6: single-node list
        walk(4'h7, 0);
        check("t6_beats", dq.size(), 1);
        if (dq.size() == 1) begin
            check("t6_data", {28'd0, dq[0]}, 9);
            check("t6_last", lq[0], 1);
        end
        check("t6_done", saw_done, 1);
        check("t6_count", node_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
